// File: rtl/data_path_pkg.sv
// rtl/data_path_pkg.sv - shared widths and control encodings for the data_path slice
package data_path_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_e;

endpackage

// File: rtl/data_path_regfile.sv
// rtl/data_path_regfile.sv - 32x32 register file, two async reads, one sync write, x0 hardwired
module regfile
  import data_path_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [4:0]      a1,
  input  logic [4:0]      a2,
  input  logic [4:0]      a3,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (a3 != 5'd0)) begin
      regs[a3] <= wd;
    end
  end

  // x0 is gated at the read port so it reads zero even before the first reset
  assign rd1 = (a1 == 5'd0) ? '0 : regs[a1];
  assign rd2 = (a2 == 5'd0) ? '0 : regs[a2];

endmodule

// File: rtl/data_path.sv
// rtl/data_path.sv - single-cycle RV32I datapath; DATAPATH_XOR_EN adds ALU xor on code 100
module data_path
  import data_path_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      ResultSrc,
  input  logic            PCSrc,
  input  logic            ALUSrc,
  input  logic            RegWrite,
  input  logic [1:0]      ImmSrc,
  input  logic [2:0]      ALUControl,
  input  logic [XLEN-1:0] Instr,
  input  logic [XLEN-1:0] ReadData,
  output logic            Zero,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] ALUResult,
  output logic [XLEN-1:0] WriteData
);

  logic [XLEN-1:0] rd1, rd2, imm_ext, src_b, result;
  logic [XLEN-1:0] pc_plus4, pc_target, pc_next;
  logic            unused_opcode;

  assign unused_opcode = ^Instr[6:0];

  always_ff @(posedge clk) begin
    if (reset) PC <= '0;
    else       PC <= pc_next;
  end

  assign pc_plus4  = PC + 32'd4;
  assign pc_target = PC + imm_ext;
  assign pc_next   = PCSrc ? pc_target : pc_plus4;

  regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (RegWrite),
    .a1    (Instr[19:15]),
    .a2    (Instr[24:20]),
    .a3    (Instr[11:7]),
    .wd    (result),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  always_comb begin
    imm_ext = '0;
    case (ImmSrc)
      IMM_I:   imm_ext = {{20{Instr[31]}}, Instr[31:20]};
      IMM_S:   imm_ext = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
      IMM_B:   imm_ext = {{20{Instr[31]}}, Instr[7], Instr[30:25], Instr[11:8], 1'b0};
      IMM_J:   imm_ext = {{12{Instr[31]}}, Instr[19:12], Instr[20], Instr[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  assign src_b     = ALUSrc ? imm_ext : rd2;
  assign WriteData = rd2;

  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      ALU_ADD: ALUResult = rd1 + src_b;
      ALU_SUB: ALUResult = rd1 - src_b;
      ALU_AND: ALUResult = rd1 & src_b;
      ALU_OR:  ALUResult = rd1 | src_b;
      ALU_SLT: ALUResult = {{(XLEN-1){1'b0}}, ($signed(rd1) < $signed(src_b))};
`ifdef DATAPATH_XOR_EN
      ALU_XOR: ALUResult = rd1 ^ src_b;
`endif
      default: ALUResult = '0;
    endcase
  end

  assign Zero = (ALUResult == '0);

  always_comb begin
    result = '0;
    case (ResultSrc)
      RES_ALU: result = ALUResult;
      RES_MEM: result = ReadData;
      RES_PC4: result = pc_plus4;
      default: result = '0;
    endcase
  end

endmodule

// File: tb/tb_data_path.sv
// tb/tb_data_path.sv - scoreboard bench for data_path against an architectural reference model
module tb_data_path;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ResultSrc;
  logic        PCSrc, ALUSrc, RegWrite;
  logic [1:0]  ImmSrc;
  logic [2:0]  ALUControl;
  logic [31:0] Instr, ReadData;
  logic        Zero;
  logic [31:0] PC, ALUResult, WriteData;

  data_path dut (
    .clk        (clk),
    .reset      (reset),
    .ResultSrc  (ResultSrc),
    .PCSrc      (PCSrc),
    .ALUSrc     (ALUSrc),
    .RegWrite   (RegWrite),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .Instr      (Instr),
    .ReadData   (ReadData),
    .Zero       (Zero),
    .PC         (PC),
    .ALUResult  (ALUResult),
    .WriteData  (WriteData)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] alu;
    logic        zero;
    logic [31:0] wd;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int step_id = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  bit          model_ok = 0;

  function automatic logic [31:0] sx(input int unsigned val, input int bits);
    int signed v;
    v = int'(val);
    if (val >= (32'd1 << (bits - 1))) v = int'(val) - (1 << bits);
    return 32'(v);
  endfunction

  function automatic logic [31:0] model_imm(input logic [1:0] sel, input logic [31:0] ins);
    int unsigned v;
    case (sel)
      2'd0: return sx(ins[31:20], 12);
      2'd1: return sx(ins[31:25] * 32 + ins[11:7], 12);
      2'd2: begin
        v = ins[31] * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2;
        return sx(v, 13);
      end
      default: begin
        v = ins[31] * (1 << 20) + ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2;
        return sx(v, 21);
      end
    endcase
  endfunction

  function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
`ifdef DATAPATH_XOR_EN
      3'd4: return a ^ b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic step(input logic rst, input logic [1:0] rsrc, input logic pcs, input logic asrc,
                      input logic rw, input logic [1:0] isrc, input logic [2:0] actl,
                      input logic [31:0] ins, input logic [31:0] rdata);
    logic [31:0] a, b, imm, alu, res, pc4, nxt;
    exp_t e;
    reset = rst; ResultSrc = rsrc; PCSrc = pcs; ALUSrc = asrc; RegWrite = rw;
    ImmSrc = isrc; ALUControl = actl; Instr = ins; ReadData = rdata;
    step_id++;
    a   = m_regs[ins[19:15]];
    b   = m_regs[ins[24:20]];
    imm = model_imm(isrc, ins);
    alu = model_alu(actl, a, asrc ? imm : b);
    pc4 = m_pc + 32'd4;
    nxt = pcs ? m_pc + imm : pc4;
    case (rsrc)
      2'd0: res = alu;
      2'd1: res = rdata;
      2'd2: res = pc4;
      default: res = 32'd0;
    endcase
    if (model_ok) begin
      e.id = step_id; e.alu = alu; e.zero = (alu == 32'd0); e.wd = b; e.pc = m_pc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_pc = 32'd0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      model_ok = 1;
    end else if (model_ok) begin
      m_pc = nxt;
      if (rw && ins[11:7] != 5'd0) m_regs[ins[11:7]] = res;
    end
  endtask

  // S-type shape with zero immediate: ALUResult shows x[rs1], WriteData shows x[rs2]
  task automatic peek(input logic [4:0] r1, input logic [4:0] r2);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd1, 3'd0, {7'd0, r2, r1, 3'd0, 5'd0, 7'h23}, 32'd0);
  endtask

  task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, id, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("ALUResult", e.id, ALUResult, e.alu);
      cmp("Zero", e.id, {31'd0, Zero}, {31'd0, e.zero});
      cmp("WriteData", e.id, WriteData, e.wd);
      cmp("PC", e.id, PC, e.pc);
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pc = 32'd0;

    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0);
    for (int i = 0; i < 32; i++) peek(5'(i), 5'(31 - i));

    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 32'h00500113, 32'h0);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 32'h00C00193, 32'h0);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 32'hFF718393, 32'h0);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd3, 32'h0023E233, 32'h0);
    peek(5'd2, 5'd3);
    peek(5'd7, 5'd4);
    // sub x0,x2,x2 with write enabled: Zero high, x0 untouched
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd1, {7'h20, 5'd2, 5'd2, 3'd0, 5'd0, 7'h33}, 32'h0);
    peek(5'd0, 5'd0);

    step(1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd0, {12'd7, 5'd0, 3'd0, 5'd9, 7'h13}, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 32'h00000013, 32'h0);
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd2, 3'd1, 32'hFE000EE3, 32'h0);
    step(1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 2'd0, 3'd0, {12'd0, 5'd0, 3'd2, 5'd5, 7'h03}, 32'hDEADBEEF);
    peek(5'd5, 5'd9);

    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 32'h00000013, 32'h0);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 32'h00000013, 32'h0);
    step(1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 2'd3, 3'd0, {20'h00000, 5'd6, 7'h6F}, 32'h0);
    peek(5'd6, 5'd5);

    // jal -4 from PC 0 exercises the 0xFFFFFFFC -> 0 wrap
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0);
    step(1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 2'd3, 3'd0, 32'hFFDFF06F, 32'h0);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 32'h00000013, 32'h0);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 32'h00000013, 32'h0);

    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 49) == 0), 2'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 2'($urandom), 3'($urandom), $urandom, $urandom);
    end
    for (int i = 1; i < 32; i++) peek(5'(i), 5'(32 - i));

    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
